// File: rtl/timer_multi.sv
// Bank of NUM_CH memory-mapped programmable down-the-bus timers with prescaler,
// periodic/one-shot mode, sticky flag, per-channel tick pulse and shared level IRQ.
module timer_multi #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter logic [15:0] BASE_ADDR      = 16'hFF40,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h004C4B40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic              we,
  input  logic [7:0]        di,
  output logic [7:0]        dout,
  output logic [NUM_CH-1:0] tick_o,
  output logic              irq
);

  localparam int NBYTES = CNT_W / 8;

  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [7:0]        presc  [NUM_CH];
  logic [7:0]        pre    [NUM_CH];
  logic [NUM_CH-1:0] en, periodic, irq_en, flag;
  logic [NUM_CH-1:0] pre_tick, evt, wr_ch;

  logic [15:0] off;
  logic        in_bank;
  logic [2:0]  ch_sel, reg_sel;
  logic [31:0] p32;

  assign off     = addr - BASE_ADDR;
  assign in_bank = (addr >= BASE_ADDR) && (off < 16'(8 * NUM_CH));
  assign ch_sel  = off[5:3];
  assign reg_sel = off[2:0];

  // Terminal compare is >= so a PERIOD lowered below CNT fires on the next tick.
  always_comb begin
    pre_tick = '0;
    evt      = '0;
    wr_ch    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pre_tick[c] = en[c] && (pre[c] == presc[c]);
      evt[c]      = pre_tick[c] && (cnt[c] >= period[c]);
      wr_ch[c]    = we && in_bank && (ch_sel == 3'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period[c] <= DEFAULT_PERIOD[CNT_W-1:0];
        cnt[c]    <= '0;
        presc[c]  <= '0;
        pre[c]    <= '0;
      end
      en       <= '1;
      periodic <= '1;
      irq_en   <= '0;
      flag     <= '0;
      tick_o   <= '0;
      irq      <= 1'b0;
    end else begin
      tick_o <= evt;
      irq    <= |(flag & irq_en);
      for (int c = 0; c < NUM_CH; c++) begin
        if (en[c]) pre[c] <= pre_tick[c] ? 8'd0 : pre[c] + 8'd1;
        if (pre_tick[c]) cnt[c] <= evt[c] ? '0 : cnt[c] + CNT_W'(1);
        if (evt[c]) begin
          flag[c] <= 1'b1;
          if (!periodic[c]) en[c] <= 1'b0;
        end
        // Bus writes come last so they win over same-cycle counter updates.
        if (wr_ch[c]) begin
          case (reg_sel)
            3'd4: begin
              en[c]       <= di[0];
              periodic[c] <= di[1];
              irq_en[c]   <= di[2];
              if (di[0] && !en[c]) begin
                cnt[c] <= '0;
                pre[c] <= '0;
              end
            end
            3'd5: begin
              if (di[0] && !evt[c]) flag[c] <= 1'b0;
              if (di[1]) begin
                cnt[c] <= '0;
                pre[c] <= '0;
              end
            end
            3'd6: presc[c] <= di;
            default: begin
              for (int b = 0; b < NBYTES; b++)
                if (reg_sel == 3'(b)) period[c][8*b +: 8] <= di;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    p32  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_bank && (ch_sel == 3'(c))) begin
        p32 = 32'(period[c]);
        case (reg_sel)
          3'd0:    dout = p32[7:0];
          3'd1:    dout = p32[15:8];
          3'd2:    dout = p32[23:16];
          3'd3:    dout = p32[31:24];
          3'd4:    dout = {5'b0, irq_en[c], periodic[c], en[c]};
          3'd5:    dout = {7'b0, flag[c]};
          3'd6:    dout = presc[c];
          default: dout = '0;
        endcase
      end
    end
  end

endmodule
